audio_pdm_out: RTL and testbench

Playback counterpart of the PDM microphone path: takes signed 16-bit PCM samples over a valid/ready stream, buffers them in a small FIFO, and converts them to a 1-bit PDM stream with a second-order delta-sigma modulator. Sample and bit cadence come from the shared audio clock generator's `stb_pcm` and bit strobes, so one output bit is produced per strobe and one sample is consumed per PCM period. `pdm_out` drives a PDM amplifier or an RC-filtered pin.

---
 rtl/audio_pdm_out_if.sv | 16 +
 rtl/audio_pdm_out.sv | 145 ++++++++++++++
 tb/tb_audio_pdm_out.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pdm_out_if.sv
//------------------------------------------------------------------------------
// audio_pdm_out_if : valid/ready stream of signed 16-bit PCM samples
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface audio_pdm_out_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/audio_pdm_out.sv
//------------------------------------------------------------------------------
// audio_pdm_out : PCM sample FIFO feeding a 2nd-order delta-sigma PDM modulator
// Option macro: AUDIO_PDM_OUT_SMOOTH_EN (one-pole interpolating low-pass on x)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module audio_pdm_out #(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  parameter int SHIFT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stb_bit_i,
  input  logic                   stb_pcm_i,
  audio_pdm_out_if.slave         s_if,
  output logic                   pdm_out_o,
  output logic                   underrun_o,
  input  logic                   clr_underrun_i,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]           C_FULL   = (AW+1)'(DEPTH);
  localparam logic signed [W+1:0]   C_SAT_HI = (W+2)'((1 << (W-2)) - 1);
  localparam logic signed [W+1:0]   C_SAT_LO = -C_SAT_HI - (W+2)'(1);
  localparam logic signed [W+1:0]   C_FB_MAG = (W+2)'(32768);

  logic [15:0]          mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic signed [15:0]   tgt_q, tgt_d;
  logic signed [W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic                 pdm_q, pdm_d;
  logic                 underrun_q, underrun_d;

  logic                 w_push, w_pop;
  logic signed [15:0]   w_popped;
  logic signed [W-1:0]  w_xs;
  logic signed [W+1:0]  w_fb, w_sum1, w_sum2;
  logic signed [W-1:0]  w_i1n, w_i2n;

  assign s_if.in_ready = (level_q != C_FULL);
  assign w_push        = s_if.in_valid && (level_q != C_FULL);
  assign w_pop         = stb_pcm_i && (level_q != '0);
  assign w_popped      = mem_q[rd_ptr_q];

  assign level_o    = level_q;
  assign pdm_out_o  = pdm_q;
  assign underrun_o = underrun_q;

`ifdef AUDIO_PDM_OUT_SMOOTH_EN
  // x carries 8 fractional bits; diff needs one extra bit to avoid wrap
  logic signed [W-1:0] x_q, x_d;
  logic signed [W:0]   w_diff;

  assign w_xs   = x_q >>> 8;
  assign w_diff = ((W+1)'(tgt_q) <<< 8) - (W+1)'(x_q);

  always_comb begin
    x_d = x_q;
    if (stb_bit_i) x_d = x_q + W'(w_diff >>> SHIFT);
  end
`else
  logic signed [15:0] x_q, x_d;

  assign w_xs = W'(x_q);

  always_comb begin
    x_d = x_q;
    if (w_pop) x_d = w_popped;
  end
`endif

  always_comb begin
    w_fb   = pdm_q ? C_FB_MAG : -C_FB_MAG;
    w_sum1 = (W+2)'(i1_q) + (W+2)'(w_xs) - w_fb;
    if (w_sum1 > C_SAT_HI)      w_i1n = W'(C_SAT_HI);
    else if (w_sum1 < C_SAT_LO) w_i1n = W'(C_SAT_LO);
    else                        w_i1n = W'(w_sum1);
    w_sum2 = (W+2)'(i2_q) + (W+2)'(w_i1n) - w_fb;
    if (w_sum2 > C_SAT_HI)      w_i2n = W'(C_SAT_HI);
    else if (w_sum2 < C_SAT_LO) w_i2n = W'(C_SAT_LO);
    else                        w_i2n = W'(w_sum2);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tgt_d      = tgt_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    pdm_d      = pdm_q;
    underrun_d = underrun_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tgt_d    = w_popped;
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // set has priority over clear
    if (stb_pcm_i && (level_q == '0)) underrun_d = 1'b1;
    else if (clr_underrun_i)          underrun_d = 1'b0;
    if (stb_bit_i) begin
      i1_d  = w_i1n;
      i2_d  = w_i2n;
      pdm_d = ~w_i2n[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= s_if.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tgt_q      <= '0;
      x_q        <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      pdm_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tgt_q      <= tgt_d;
      x_q        <= x_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      pdm_q      <= pdm_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_audio_pdm_out.sv
//------------------------------------------------------------------------------
// tb_audio_pdm_out : directed-vector bench for audio_pdm_out
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_audio_pdm_out;
  localparam int DEPTH = 4;
  localparam int SAT   = (1 << 22);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb_bit = 1'b0;
  logic       stb_pcm = 1'b0;
  logic       clr = 1'b0;
  logic       pdm;
  logic       und;
  logic [2:0] level;
  int         total = 0;
  int         bad = 0;

  audio_pdm_out_if bus ();

  audio_pdm_out #(.W(24), .DEPTH(DEPTH), .SHIFT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stb_bit_i      (stb_bit),
    .stb_pcm_i      (stb_pcm),
    .s_if           (bus),
    .pdm_out_o      (pdm),
    .underrun_o     (und),
    .clr_underrun_i (clr),
    .level_o        (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic one_bit();
    stb_bit = 1'b1;
    step();
    stb_bit = 1'b0;
  endtask

  task automatic one_pcm();
    stb_pcm = 1'b1;
    step();
    stb_pcm = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      one_bit();
      ones += int'(pdm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    total++; if (pdm !== 1'b0)   begin bad++; $display("FAIL reset_pdm got=%0b exp=0", pdm); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.in_ready); end
    total++; if (und !== 1'b0)   begin bad++; $display("FAIL reset_underrun got=%0b exp=0", und); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_bits();
    int exp_bits[4] = '{1, 1, 0, 1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      one_bit();
      total++;
      if (pdm !== 1'(exp_bits[k])) begin
        bad++; $display("FAIL first_bit%0d got=%0b exp=%0d", k, pdm, exp_bits[k]);
      end
    end
  endtask

  task automatic test_underrun();
    int ones;
    apply_reset();
    one_pcm();
    total++; if (und !== 1'b1) begin bad++; $display("FAIL underrun_set got=%0b exp=1", und); end
    count_ones(1000, ones);
    total++;
    if (ones < 498 || ones > 502) begin bad++; $display("FAIL zero_density ones=%0d exp=500+-2", ones); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (und !== 1'b0) begin bad++; $display("FAIL underrun_clr got=%0b exp=0", und); end
    clr = 1'b1;
    stb_pcm = 1'b1;
    step();
    clr = 1'b0;
    stb_pcm = 1'b0;
    total++; if (und !== 1'b1) begin bad++; $display("FAIL underrun_set_wins got=%0b exp=1", und); end
  endtask

  task automatic test_density();
    int ones;
    apply_reset();
    push(16'sd16384);
    one_pcm();
`ifdef AUDIO_PDM_OUT_SMOOTH_EN
    count_ones(200, ones);
    count_ones(1800, ones);
    total++;
    if (ones < 1346 || ones > 1354) begin bad++; $display("FAIL smooth_density ones=%0d exp=1350+-4", ones); end
`else
    count_ones(2000, ones);
    total++;
    if (ones < 1496 || ones > 1504) begin bad++; $display("FAIL half_density ones=%0d exp=1500+-4", ones); end
`endif
  endtask

  task automatic test_full_negative();
    int ones = 0;
    int out_of_range = 0;
    apply_reset();
    push(16'h8000);
    one_pcm();
    for (int k = 0; k < 2000; k++) begin
      one_bit();
      ones += int'(pdm);
      if ($signed(dut.i1_q) > SAT - 1 || $signed(dut.i1_q) < -SAT ||
          $signed(dut.i2_q) > SAT - 1 || $signed(dut.i2_q) < -SAT)
        out_of_range++;
    end
    total++; if (ones > 4) begin bad++; $display("FAIL neg_fullscale ones=%0d exp<=4", ones); end
    total++; if (out_of_range != 0) begin bad++; $display("FAIL integ_bounds violations=%0d exp=0", out_of_range); end
    total++;
    if ($signed(dut.i2_q) != -SAT) begin
      bad++; $display("FAIL i2_saturated got=%0d exp=%0d", $signed(dut.i2_q), -SAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[5] = '{16'd100, 16'd200, 16'hFF38, 16'd400, 16'd500};
    apply_reset();
    for (int k = 0; k < DEPTH + 1; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vals[k];
      step();
      if (k == DEPTH - 1) begin
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", level); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", bus.in_ready); end
      end
    end
    bus.in_valid = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL extra_refused level=%0d exp=4", level); end
    for (int k = 0; k < DEPTH; k++) begin
      one_pcm();
      total++;
      if (dut.tgt_q !== vals[k]) begin bad++; $display("FAIL pop_order%0d got=%0h exp=%0h", k, dut.tgt_q, vals[k]); end
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL drained_level got=%0d exp=0", level); end
    total++; if (und !== 1'b0) begin bad++; $display("FAIL no_underrun_yet got=%0b exp=0", und); end
    one_pcm();
    total++; if (und !== 1'b1) begin bad++; $display("FAIL empty_pop_underrun got=%0b exp=1", und); end
    total++; if (dut.tgt_q !== vals[3]) begin bad++; $display("FAIL tgt_hold got=%0h exp=%0h", dut.tgt_q, vals[3]); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int k = 0; k < DEPTH; k++) push(16'h8000);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1234;
    stb_pcm      = 1'b1;
    stb_bit      = 1'b1;
    step();
    bus.in_valid = 1'b0;
    stb_pcm      = 1'b0;
    stb_bit      = 1'b0;
    total++; if (level !== 3'd3) begin bad++; $display("FAIL simul_level got=%0d exp=3", level); end
    total++; if (pdm !== 1'b1) begin bad++; $display("FAIL simul_bit0 got=%0b exp=1", pdm); end
    one_bit();
    total++; if (pdm !== 1'b1) begin bad++; $display("FAIL simul_bit1_old_x got=%0b exp=1", pdm); end
    one_bit();
    total++; if (pdm !== 1'b0) begin bad++; $display("FAIL simul_bit2 got=%0b exp=0", pdm); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push(16'd100);
    one_pcm();
    one_bit();
    push(16'd200);
    total++; if (pdm !== 1'b1 || level !== 3'd1) begin
      bad++; $display("FAIL pre_reset pdm=%0b level=%0d exp=1/1", pdm, level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pdm !== 1'b0)   begin bad++; $display("FAIL async_pdm got=%0b exp=0", pdm); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL async_level got=%0d exp=0", level); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL async_ready got=%0b exp=1", bus.in_ready); end
    step();
    rst_n = 1'b1;
    step();
    one_bit();
    total++; if (pdm !== 1'b1) begin bad++; $display("FAIL post_reset_bit got=%0b exp=1", pdm); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_first_bits();
    test_underrun();
    test_density();
    test_full_negative();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
